// File: rtl/image_loader_pkg.sv
// Shared encodings for the frame loader: FSM states and per-frame pixel modes.
package image_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_COPY = 2'b00,
    MODE_INV  = 2'b01,
    MODE_THR  = 2'b10,
    MODE_BRT  = 2'b11
  } mode_t;

endpackage

// File: rtl/image_loader_pixel_op.sv
// Combinational per-pixel operation; shared with later filter stages.
module pixel_op
  import image_loader_pkg::*;
#(
  parameter logic [7:0] THRESH = 8'd128,
  parameter logic [7:0] BRIGHT = 8'd32
) (
  input  mode_t      mode_i,
  input  logic [7:0] d_i,
  output logic [7:0] res_o
);

  logic [8:0] sum;

  always_comb begin
    // Brighten is computed in 9 bits so the carry flags saturation.
    sum   = {1'b0, d_i} + {1'b0, BRIGHT};
    res_o = d_i;
    case (mode_i)
      MODE_COPY: res_o = d_i;
      MODE_INV:  res_o = 8'hFF - d_i;
      MODE_THR:  res_o = (d_i >= THRESH) ? 8'hFF : 8'h00;
      MODE_BRT:  res_o = sum[8] ? 8'hFF : sum[7:0];
      default:   res_o = d_i;
    endcase
  end

endmodule

// File: rtl/image_loader.sv
// Writes processed FIFO bytes sequentially into the frame RAM, one frame per start.
module image_loader
  import image_loader_pkg::*;
#(
  parameter int          WIDTH  = 160,
  parameter int          HEIGHT = 120,
  parameter int          ADDR_W = 15,
  parameter logic [7:0]  THRESH = 8'd128,
  parameter logic [7:0]  BRIGHT = 8'd32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              rd_tick,
  input  logic [7:0]        rx_data,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        wdata,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH * HEIGHT - 1);

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              accept;
  logic [7:0]        pix;

  pixel_op #(
    .THRESH (THRESH),
    .BRIGHT (BRIGHT)
  ) u_pixel_op (
    .mode_i (mode_q),
    .d_i    (rx_data),
    .res_o  (pix)
  );

  // start always wins over a coincident pop, so that byte is dropped.
  assign accept = rd_tick && !start && (state_q == LOAD);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    ovf_d   = ovf_q;

    if (start) begin
      state_d = LOAD;
      cnt_d   = '0;
      mode_d  = mode_t'(mode);
      ovf_d   = 1'b0;
    end

    if (rd_tick && !accept) ovf_d = 1'b1;

    if (accept) begin
      we_d    = 1'b1;
      addr_d  = cnt_q;
      wdata_d = pix;
      // Counter parks on the last index instead of wrapping.
      if (cnt_q == LAST) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
    end

    busy_d = (state_d == LOAD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_COPY;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign we         = we_q;
  assign addr       = addr_q;
  assign wdata      = wdata_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overflow   = ovf_q;

endmodule
